dmem_unit: RTL and testbench

//   Data-memory stage consumed by the pipelined CPU's MEM stage. Takes the CPU's memory

---
 rtl/dmem_unit.sv | 154 +++++++++++++++
 tb/tb_dmem_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// Data-memory stage: byte-lane stores, extended combinational loads,
// sticky fault capture and saturating access counters.
module dmem_unit #(
    parameter int DEPTH_WORDS = 128,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_w,
    input  logic             mem_r,
    input  logic [31:0]      addr,
    input  logic [31:0]      din,
    input  logic [2:0]       dm_ctrl,
    output logic [31:0]      dout,
    output logic             err_misal,
    output logic             err_range,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int              AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]     LIMIT   = 33'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          is_word;
    logic          is_half;
    logic          is_byte;
    logic          is_uns;
    logic          in_range;
    logic          misal;
    logic          valid;
    logic          fault;
    logic          do_store;
    logic          do_load;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;
    logic [31:0]   wr_data;
    logic [3:0]    be;

    // Decode access size; unused codes fall back to word
    always_comb begin
        is_word = 1'b0;
        is_half = 1'b0;
        is_byte = 1'b0;
        is_uns  = 1'b0;
        unique case (dm_ctrl)
            3'b001: is_half = 1'b1;
            3'b010: begin
                is_half = 1'b1;
                is_uns  = 1'b1;
            end
            3'b011: is_byte = 1'b1;
            3'b100: begin
                is_byte = 1'b1;
                is_uns  = 1'b1;
            end
            default: is_word = 1'b1;
        endcase
    end

    assign in_range = ({1'b0, addr} < LIMIT);
    assign misal    = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);
    assign valid    = in_range & ~misal;
    assign fault    = ~valid;
    assign do_store = mem_w & valid;
    assign do_load  = mem_r & ~mem_w & valid;
    assign idx      = addr[AW+1:2];
    assign rd_word  = mem[idx];
    assign rd_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];

    // Pick the addressed byte lane
    always_comb begin
        rd_byte = rd_word[7:0];
        unique case (addr[1:0])
            2'b00: rd_byte = rd_word[7:0];
            2'b01: rd_byte = rd_word[15:8];
            2'b10: rd_byte = rd_word[23:16];
            2'b11: rd_byte = rd_word[31:24];
        endcase
    end

    // Extend load data; invalid accesses read as zero
    always_comb begin
        dout = 32'h0;
        if (valid) begin
            if (is_half) begin
                dout = {{16{~is_uns & rd_half[15]}}, rd_half};
            end else if (is_byte) begin
                dout = {{24{~is_uns & rd_byte[7]}}, rd_byte};
            end else begin
                dout = rd_word;
            end
        end
    end

    // Replicate store data across lanes and build byte enables
    always_comb begin
        wr_data = din;
        be      = 4'hF;
        if (is_half) begin
            wr_data = {2{din[15:0]}};
            be      = addr[1] ? 4'b1100 : 4'b0011;
        end else if (is_byte) begin
            wr_data = {4{din[7:0]}};
            be      = 4'b0001 << addr[1:0];
        end
    end

    // Byte-lane merged write; suppressed during reset
    always_ff @(posedge clk) begin
        if (!rst && do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Saturating counters and sticky fault capture
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            err_misal <= 1'b0;
            err_range <= 1'b0;
            err_addr  <= 32'h0;
        end else begin
            if (do_store && store_cnt != CNT_MAX) begin
                store_cnt <= store_cnt + 1'b1;
            end
            if (do_load && load_cnt != CNT_MAX) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if ((mem_r | mem_w) && fault) begin
                if (!err_misal && !err_range) begin
                    err_addr <= addr;
                end
                if (!in_range) begin
                    err_range <= 1'b1;
                end
                if (misal) begin
                    err_misal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed scenarios plus random traffic
// against a byte-array reference model.
module tb_dmem_unit;

    localparam int DEPTH = 128;
    localparam int CW    = 16;
    localparam int NBYTE = 4 * DEPTH;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          mem_w;
    logic          mem_r;
    logic [31:0]   addr;
    logic [31:0]   din;
    logic [2:0]    dm_ctrl;
    logic [31:0]   dout;
    logic          err_misal;
    logic          err_range;
    logic [31:0]   err_addr;
    logic [CW-1:0] load_cnt;
    logic [CW-1:0] store_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mm [NBYTE];
    int          m_lcnt;
    int          m_scnt;
    bit          m_misal;
    bit          m_range;
    logic [31:0] m_eaddr;

    dmem_unit #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .addr      (addr),
        .din       (din),
        .dm_ctrl   (dm_ctrl),
        .dout      (dout),
        .err_misal (err_misal),
        .err_range (err_range),
        .err_addr  (err_addr),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_size(logic [2:0] c);
        if (c == 3'd1 || c == 3'd2) return 2;
        if (c == 3'd3 || c == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_uns(logic [2:0] c);
        return (c == 3'd2 || c == 3'd4);
    endfunction

    function automatic bit m_inr(logic [31:0] a);
        return a < NBYTE;
    endfunction

    function automatic bit m_mis(logic [31:0] a, logic [2:0] c);
        return (a % m_size(c)) != 0;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] a, logic [2:0] c);
        int n;
        logic [31:0] v;
        n = m_size(c);
        v = 32'h0;
        if (!m_inr(a) || m_mis(a, c)) return 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[int'(a) + i]) << (8 * i));
        if (n < 4 && !m_uns(c) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_step();
        bit ok;
        if (rst) begin
            m_lcnt  = 0;
            m_scnt  = 0;
            m_misal = 0;
            m_range = 0;
            m_eaddr = 32'h0;
            return;
        end
        ok = m_inr(addr) && !m_mis(addr, dm_ctrl);
        if (ok && mem_w) begin
            for (int i = 0; i < m_size(dm_ctrl); i++)
                mm[int'(addr) + i] = din[8*i +: 8];
            if (m_scnt < CMAX) m_scnt++;
        end else if (ok && mem_r) begin
            if (m_lcnt < CMAX) m_lcnt++;
        end
        if ((mem_r || mem_w) && !ok) begin
            if (!m_misal && !m_range) m_eaddr = addr;
            if (!m_inr(addr)) m_range = 1;
            if (m_mis(addr, dm_ctrl)) m_misal = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_lcnt"}, 32'(load_cnt), 32'(m_lcnt));
        chk({tag, "_scnt"}, 32'(store_cnt), 32'(m_scnt));
        chk({tag, "_emis"}, 32'(err_misal), 32'(m_misal));
        chk({tag, "_erng"}, 32'(err_range), 32'(m_range));
        chk({tag, "_eadr"}, err_addr, m_eaddr);
    endtask

    task automatic setin(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
        mem_w   = w;
        mem_r   = r;
        addr    = a;
        din     = d;
        dm_ctrl = c;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    // One full access: model dout check, optional constant check, edge, state check
    task automatic op(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] c,
                      input string tag, input bit use_want, input logic [31:0] want);
        setin(w, r, a, d, c);
        #2;
        chk({tag, "_dout"}, dout, m_load(a, c));
        if (use_want) chk({tag, "_want"}, dout, want);
        tick();
        chk_state(tag);
    endtask

    initial begin
        rst = 1'b1;
        setin(0, 0, 32'h0, 32'h0, 3'd0);
        m_lcnt = 0; m_scnt = 0; m_misal = 0; m_range = 0; m_eaddr = 0;
        @(posedge clk); #1;
        m_step();
        chk_state("reset");
        chk("reset_scnt0", 32'(store_cnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            setin(1, 0, 32'(4 * i), $urandom, 3'd0);
            tick();
        end
        chk_state("init");

        op(1, 0, 32'h10, 32'h8000_00FF, 3'd0, "t1_sw", 0, 0);
        op(0, 1, 32'h10, 0, 3'd3, "t1_lb", 1, 32'hFFFF_FFFF);
        op(0, 1, 32'h10, 0, 3'd4, "t1_lbu", 1, 32'h0000_00FF);
        op(0, 1, 32'h12, 0, 3'd1, "t1_lh", 1, 32'hFFFF_8000);

        op(1, 0, 32'h20, 32'h1122_3344, 3'd0, "t2_sw", 0, 0);
        op(1, 0, 32'h21, 32'h0000_00AA, 3'd3, "t2_sb", 0, 0);
        op(1, 0, 32'h22, 32'h0000_BEEF, 3'd1, "t2_sh", 0, 0);
        op(0, 1, 32'h20, 0, 3'd0, "t2_lw", 1, 32'hBEEF_AA44);
        op(0, 1, 32'h22, 0, 3'd2, "t2_lhu", 1, 32'h0000_BEEF);
        op(0, 1, 32'h21, 0, 3'd3, "t2_lb", 1, 32'hFFFF_FFAA);

        op(1, 0, 32'h30, 32'h9, 3'd0, "t6_sw", 0, 0);
        op(1, 1, 32'h30, 32'h5, 3'd0, "t6_rw", 1, 32'h9);
        op(0, 1, 32'h30, 0, 3'd0, "t6_lw", 1, 32'h5);

        op(1, 0, 32'h22, 32'hDEAD_BEEF, 3'd0, "t3_sw", 0, 0);
        chk("t3_misal", 32'(err_misal), 32'h1);
        chk("t3_eaddr", err_addr, 32'h22);
        op(0, 1, 32'h20, 0, 3'd0, "t3_lw", 1, 32'hBEEF_AA44);
        op(0, 1, 32'h1001, 0, 3'd1, "t3_lh", 1, 32'h0);
        chk("t3_eaddr2", err_addr, 32'h22);

        op(0, 1, 32'(NBYTE), 0, 3'd0, "t4_lw", 1, 32'h0);
        chk("t4_range", 32'(err_range), 32'h1);
        op(0, 0, 32'(NBYTE), 0, 3'd0, "t4_idle", 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = (($urandom & 7) == 0) ? 32'($urandom_range(NBYTE, NBYTE + 64))
                                       : 32'($urandom_range(0, NBYTE - 1));
            op(1'($urandom), 1'($urandom), a, $urandom, 3'($urandom), "rnd", 0, 0);
        end

        op(1, 0, 32'h40, 32'hCAFE_F00D, 3'd0, "t5_keep", 0, 0);
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            setin(1, 0, 32'h44, 32'(i), 3'd0);
            tick();
        end
        chk("t5_sat", 32'(store_cnt), 32'(CMAX));
        chk_state("t5_sat");

        rst = 1'b1;
        setin(1, 0, 32'h40, 32'h1234_5678, 3'd0);
        tick();
        rst = 1'b0;
        setin(0, 0, 32'h40, 0, 3'd0);
        #1;
        chk_state("t5_rst");
        chk("t5_rst_scnt", 32'(store_cnt), 32'h0);
        chk("t5_rst_emis", 32'(err_misal), 32'h0);
        op(0, 1, 32'h40, 0, 3'd0, "t5_lw", 1, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
